// File: rtl/ysyx_24070014_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding,
// default counter width and the reset PC used by the surrounding core.
package ysyx_24070014_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MEM_REQ    = 3'd3,
    MEM_WAIT   = 3'd4,
    WB         = 3'd5,
    HALT       = 3'd6
  } ctrlState_e;

  localparam int CNT_WIDTH_DEFAULT = 64;

  localparam logic [31:0] INIT_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24070014_multicycle_ctrl_perf_counter.sv
// Free-running performance counter with enable and synchronous clear;
// wraps modulo 2^WIDTH.
module ysyx_24070014_perf_counter
  import ysyx_24070014_multicycle_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ysyx_24070014_multicycle_ctrl.sv
// Multi-cycle instruction sequencer with valid/ready fetch and data ports.
// Optional wait-state watchdog enabled by YSYX_24070014_BUS_TIMEOUT_EN.
module ysyx_24070014_multicycle_ctrl
  import ysyx_24070014_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
`ifdef YSYX_24070014_BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output logic                 o_ifu_req_valid,
  input  logic                 i_ifu_req_ready,
  input  logic                 i_ifu_resp_valid,
  output logic                 o_inst_latch_en,
  input  logic                 i_dec_is_load,
  input  logic                 i_dec_is_store,
  input  logic                 i_dec_reg_write,
  input  logic                 i_dec_ecall,
  input  logic                 i_dec_ebreak,
  output logic                 o_lsu_req_valid,
  input  logic                 i_lsu_req_ready,
  input  logic                 i_lsu_resp_valid,
  output logic                 o_rf_write_en,
  output logic                 o_pc_write_en,
  output logic                 o_retire,
  output logic                 o_trap_ecall,
  output logic                 o_trap_ebreak,
  output logic                 o_halted,
  output logic [CNT_WIDTH-1:0] o_mcycle,
  output logic [CNT_WIDTH-1:0] o_minstret,
  output logic                 o_bus_error
);

  ctrlState_e r_state;

  logic w_live;
  logic w_inFetchReq;
  logic w_inFetchWait;
  logic w_inExec;
  logic w_inMemReq;
  logic w_inWb;

`ifdef YSYX_24070014_BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] r_waitCount;
  logic              r_busError;
  logic              w_stalled;

  assign w_stalled = (w_inFetchReq  && !i_ifu_req_ready)  ||
                     (w_inFetchWait && !i_ifu_resp_valid) ||
                     (w_inMemReq    && !i_lsu_req_ready)  ||
                     ((r_state == MEM_WAIT) && !i_lsu_resp_valid);
`endif

  // Strobes are masked while reset is held so a memory never sees a
  // request the sequencer is about to forget.
  assign w_live        = !i_reset;
  assign w_inFetchReq  = (r_state == FETCH_REQ);
  assign w_inFetchWait = (r_state == FETCH_WAIT);
  assign w_inExec      = (r_state == EXEC)  && w_live;
  assign w_inMemReq    = (r_state == MEM_REQ);
  assign w_inWb        = (r_state == WB)    && w_live;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= FETCH_REQ;
`ifdef YSYX_24070014_BUS_TIMEOUT_EN
      r_waitCount <= '0;
      r_busError  <= 1'b0;
`endif
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (i_ifu_req_ready) begin
            r_state <= i_ifu_resp_valid ? EXEC : FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (i_ifu_resp_valid) begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (i_dec_ebreak) begin
            r_state <= HALT;
          end else if (i_dec_ecall) begin
            r_state <= WB;
          end else if (i_dec_is_load || i_dec_is_store) begin
            r_state <= MEM_REQ;
          end else begin
            r_state <= WB;
          end
        end
        MEM_REQ: begin
          if (i_lsu_req_ready) begin
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (i_lsu_resp_valid) begin
            r_state <= WB;
          end
        end
        WB:       r_state <= FETCH_REQ;
        HALT:     r_state <= HALT;
        default:  r_state <= FETCH_REQ;
      endcase
`ifdef YSYX_24070014_BUS_TIMEOUT_EN
      // Any state change restarts the count, so each wait phase gets its own budget.
      if (w_stalled) begin
        if (r_waitCount == WAIT_LAST) begin
          r_state    <= HALT;
          r_busError <= 1'b1;
        end else begin
          r_waitCount <= r_waitCount + WAIT_W'(1);
        end
      end else begin
        r_waitCount <= '0;
      end
`endif
    end
  end

  assign o_ifu_req_valid = w_inFetchReq && w_live;
  assign o_inst_latch_en = w_live && i_ifu_resp_valid &&
                           ((w_inFetchReq && i_ifu_req_ready) || w_inFetchWait);
  assign o_lsu_req_valid = w_inMemReq && w_live;
  assign o_trap_ebreak   = w_inExec && i_dec_ebreak;
  assign o_trap_ecall    = w_inExec && i_dec_ecall && !i_dec_ebreak;
  assign o_rf_write_en   = w_inWb && i_dec_reg_write && !i_dec_is_store;
  assign o_pc_write_en   = w_inWb;
  assign o_retire        = w_inWb || o_trap_ebreak;
  assign o_halted        = (r_state == HALT);

`ifdef YSYX_24070014_BUS_TIMEOUT_EN
  assign o_bus_error = r_busError;
`else
  assign o_bus_error = 1'b0;
`endif

  ysyx_24070014_perf_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_mcycle (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_en    (1'b1),
    .o_count (o_mcycle)
  );

  ysyx_24070014_perf_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_minstret (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_en    (o_retire),
    .o_count (o_minstret)
  );

endmodule

// File: tb/tb_ysyx_24070014_multicycle_ctrl.sv
// Self-checking bench for the multi-cycle sequencer: an instruction-progress
// model checked every cycle plus hand-computed milestones per scenario.
module tb_ysyx_24070014_multicycle_ctrl;

  localparam int CW   = 8;
  localparam int TOUT = 16;

  // {load, store, regWrite, ecall, ebreak}
  localparam logic [4:0] D_NONE  = 5'b00000;
  localparam logic [4:0] D_ALU   = 5'b00100;
  localparam logic [4:0] D_LOAD  = 5'b10100;
  localparam logic [4:0] D_STORE = 5'b01100;
  localparam logic [4:0] D_ECALL = 5'b00010;
  localparam logic [4:0] D_BOTH  = 5'b00011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ifuReqReady = 1'b1;
  logic ifuRespValid = 1'b1;
  logic lsuReqReady = 1'b1;
  logic lsuRespValid = 1'b1;
  logic decLoad = 1'b0;
  logic decStore = 1'b0;
  logic decRegWrite = 1'b0;
  logic decEcall = 1'b0;
  logic decEbreak = 1'b0;

  logic          ifuReqValid;
  logic          instLatchEn;
  logic          lsuReqValid;
  logic          rfWriteEn;
  logic          pcWriteEn;
  logic          retire;
  logic          trapEcall;
  logic          trapEbreak;
  logic          halted;
  logic [CW-1:0] mcycle;
  logic [CW-1:0] minstret;
  logic          busError;

  always #5 clk = ~clk;

  ysyx_24070014_multicycle_ctrl #(
    .CNT_WIDTH(CW)
`ifdef YSYX_24070014_BUS_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TOUT)
`endif
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .o_ifu_req_valid  (ifuReqValid),
    .i_ifu_req_ready  (ifuReqReady),
    .i_ifu_resp_valid (ifuRespValid),
    .o_inst_latch_en  (instLatchEn),
    .i_dec_is_load    (decLoad),
    .i_dec_is_store   (decStore),
    .i_dec_reg_write  (decRegWrite),
    .i_dec_ecall      (decEcall),
    .i_dec_ebreak     (decEbreak),
    .o_lsu_req_valid  (lsuReqValid),
    .i_lsu_req_ready  (lsuReqReady),
    .i_lsu_resp_valid (lsuRespValid),
    .o_rf_write_en    (rfWriteEn),
    .o_pc_write_en    (pcWriteEn),
    .o_retire         (retire),
    .o_trap_ecall     (trapEcall),
    .o_trap_ebreak    (trapEbreak),
    .o_halted         (halted),
    .o_mcycle         (mcycle),
    .o_minstret       (minstret),
    .o_bus_error      (busError)
  );

  int checksTotal  = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance n rising edges, leaving inputs to change just after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ifuRdy, input logic ifuRsp,
                               input logic lsuRdy, input logic lsuRsp,
                               input logic [4:0] dec, input int cycles);
    ifuReqReady  = ifuRdy;
    ifuRespValid = ifuRsp;
    lsuReqReady  = lsuRdy;
    lsuRespValid = lsuRsp;
    {decLoad, decStore, decRegWrite, decEcall, decEbreak} = dec;
    tick(cycles);
  endtask

  // Window activity counts and retire timestamps observed on the DUT pins.
  int nLatch, nRetire, nLsuValid, nRf, nIfuValid, nEcall, nEbreak;
  int relCycle;
  int retireAt[$];

  task automatic clearCounts();
    nLatch = 0; nRetire = 0; nLsuValid = 0; nRf = 0;
    nIfuValid = 0; nEcall = 0; nEbreak = 0;
  endtask

  // Model: track how far the current instruction has progressed rather
  // than which controller state it is in.
  logic          mHalted, mFetchAcc, mHaveInst, mExecDone, mIsMem;
  logic          mMemAcc, mMemDone, mBusErr;
  logic [CW-1:0] expMcycle, expMinstret;
  int            mWait;

  initial begin
    mHalted = 0; mFetchAcc = 0; mHaveInst = 0; mExecDone = 0; mIsMem = 0;
    mMemAcc = 0; mMemDone = 0; mBusErr = 0; mWait = 0;
    expMcycle = '0; expMinstret = '0; relCycle = 0;
    clearCounts();
  end

  task automatic modelDropInst();
    mFetchAcc = 0; mHaveInst = 0; mExecDone = 0; mIsMem = 0;
    mMemAcc = 0; mMemDone = 0;
  endtask

  always @(negedge clk) begin : compareModel
    logic live, inFR, inFW, inEX, inMR, inMW, inWB;
    logic waiting, advancing;
    logic [9:0] expVec, actVec;
    logic eIfu, eLatch, eLsu, eRf, ePc, eEbk, eEcl, eRet;

    live = !reset;
    inFR = !mHalted && !mHaveInst && !mFetchAcc;
    inFW = !mHalted && !mHaveInst && mFetchAcc;
    inEX = !mHalted && mHaveInst && !mExecDone;
    inMR = mExecDone && mIsMem && !mMemAcc;
    inMW = mExecDone && mIsMem && mMemAcc && !mMemDone;
    inWB = mExecDone && (!mIsMem || mMemDone);

    eIfu   = live && inFR;
    eLatch = live && ifuRespValid && ((inFR && ifuReqReady) || inFW);
    eLsu   = live && inMR;
    eRf    = live && inWB && decRegWrite && !decStore;
    ePc    = live && inWB;
    eEbk   = live && inEX && decEbreak;
    eEcl   = live && inEX && decEcall && !decEbreak;
    eRet   = ePc || eEbk;

    expVec = {eIfu, eLatch, eLsu, eRf, ePc, eRet, eEcl, eEbk, mHalted, mBusErr};
    actVec = {ifuReqValid, instLatchEn, lsuReqValid, rfWriteEn, pcWriteEn,
              retire, trapEcall, trapEbreak, halted, busError};
    checkOutput("strobes", 64'(actVec), 64'(expVec));
    checkOutput("mcycle", 64'(mcycle), 64'(expMcycle));
    checkOutput("minstret", 64'(minstret), 64'(expMinstret));

    if (reset) relCycle = 0;
    else relCycle++;
    if (retire)      begin nRetire++; retireAt.push_back(relCycle); end
    if (instLatchEn) nLatch++;
    if (lsuReqValid) nLsuValid++;
    if (rfWriteEn)   nRf++;
    if (ifuReqValid) nIfuValid++;
    if (trapEcall)   nEcall++;
    if (trapEbreak)  nEbreak++;

    if (reset) begin
      modelDropInst();
      mHalted = 0; mBusErr = 0; mWait = 0;
      expMcycle = '0; expMinstret = '0;
    end else begin
      expMcycle = expMcycle + CW'(1);
      if (eRet) expMinstret = expMinstret + CW'(1);
      waiting   = inFR || inFW || inMR || inMW;
      advancing = (inFR && ifuReqReady) || (inFW && ifuRespValid) ||
                  (inMR && lsuReqReady) || (inMW && lsuRespValid);
      if (inFR && ifuReqReady) begin
        if (ifuRespValid) mHaveInst = 1;
        else mFetchAcc = 1;
      end else if (inFW && ifuRespValid) begin
        mHaveInst = 1; mFetchAcc = 0;
      end else if (inEX) begin
        if (decEbreak) begin
          modelDropInst();
          mHalted = 1;
        end else begin
          mExecDone = 1;
          mIsMem = !decEcall && (decLoad || decStore);
        end
      end else if (inMR && lsuReqReady) begin
        mMemAcc = 1;
      end else if (inMW && lsuRespValid) begin
        mMemDone = 1;
      end else if (inWB) begin
        modelDropInst();
      end
`ifdef YSYX_24070014_BUS_TIMEOUT_EN
      if (waiting && !advancing) begin
        mWait++;
        if (mWait == TOUT) begin
          modelDropInst();
          mHalted = 1; mBusErr = 1;
        end
      end else begin
        mWait = 0;
      end
`else
      if (waiting && !advancing) mWait++;
      else mWait = 0;
`endif
    end
  end

  initial begin : stimulus
    int expRet[4];
    expRet = '{3, 6, 9, 12};

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    retireAt.delete();
    clearCounts();

    // Four ALU instructions against zero-wait memories.
    applyStimulus(1, 1, 1, 1, D_ALU, 12);
    checkOutput("alu_retire_count", 64'(retireAt.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < retireAt.size()) checkOutput("alu_retire_cycle", 64'(retireAt[i]), 64'(expRet[i]));
    end
    checkOutput("alu_mcycle", 64'(mcycle), 64'd12);
    checkOutput("alu_minstret", 64'(minstret), 64'd4);

    // Fetch: ready held off 2 cycles, data 5 cycles after acceptance.
    clearCounts();
    applyStimulus(0, 0, 1, 1, D_ALU, 2);
    applyStimulus(1, 0, 1, 1, D_ALU, 1);
    applyStimulus(0, 0, 1, 1, D_ALU, 4);
    applyStimulus(0, 1, 1, 1, D_ALU, 1);
    applyStimulus(0, 0, 1, 1, D_ALU, 2);
    checkOutput("slowfetch_latch", 64'(nLatch), 64'd1);
    checkOutput("slowfetch_retire", 64'(nRetire), 64'd1);
    checkOutput("slowfetch_ifu_valid", 64'(nIfuValid), 64'd3);

    // Load: request refused 3 cycles, response on the 2nd wait cycle.
    clearCounts();
    applyStimulus(1, 1, 0, 0, D_LOAD, 2);
    applyStimulus(1, 1, 0, 0, D_LOAD, 3);
    applyStimulus(1, 1, 1, 0, D_LOAD, 1);
    applyStimulus(1, 1, 0, 0, D_LOAD, 1);
    applyStimulus(1, 1, 0, 1, D_LOAD, 1);
    applyStimulus(1, 1, 0, 0, D_LOAD, 1);
    checkOutput("load_lsu_valid", 64'(nLsuValid), 64'd4);
    checkOutput("load_rf_write", 64'(nRf), 64'd1);
    checkOutput("load_retire", 64'(nRetire), 64'd1);

    clearCounts();
    applyStimulus(1, 1, 1, 1, D_STORE, 5);
    checkOutput("store_rf_write", 64'(nRf), 64'd0);
    checkOutput("store_retire", 64'(nRetire), 64'd1);

    clearCounts();
    applyStimulus(1, 1, 1, 1, D_ECALL, 3);
    checkOutput("ecall_trap", 64'(nEcall), 64'd1);
    checkOutput("ecall_retire", 64'(nRetire), 64'd1);

    // ecall and ebreak together: ebreak wins and the core halts.
    clearCounts();
    applyStimulus(1, 1, 1, 1, D_BOTH, 2);
    checkOutput("ebreak_trap", 64'(nEbreak), 64'd1);
    checkOutput("ebreak_no_ecall", 64'(nEcall), 64'd0);
    checkOutput("ebreak_halted", 64'(halted), 64'd1);
    checkOutput("ebreak_minstret", 64'(minstret), 64'd9);
    checkOutput("ebreak_mcycle", 64'(mcycle), 64'd41);
    clearCounts();
    applyStimulus(1, 1, 1, 1, D_ALU, 100);
    checkOutput("halt_minstret", 64'(minstret), 64'd9);
    checkOutput("halt_mcycle", 64'(mcycle), 64'd141);
    checkOutput("halt_ifu_valid", 64'(nIfuValid), 64'd0);

    // Reset while a load waits for its response.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    applyStimulus(1, 1, 1, 0, D_LOAD, 4);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_lsu_valid", 64'(lsuReqValid), 64'd0);
    checkOutput("rst_mcycle", 64'(mcycle), 64'd0);
    checkOutput("rst_minstret", 64'(minstret), 64'd0);
    reset = 1'b0;
    clearCounts();
    applyStimulus(0, 0, 1, 1, D_LOAD, 3);
    checkOutput("rst_stale_rf", 64'(nRf), 64'd0);
    checkOutput("rst_ifu_valid", 64'(nIfuValid), 64'd3);

    // Fetch port that never accepts.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
`ifdef YSYX_24070014_BUS_TIMEOUT_EN
    applyStimulus(0, 0, 1, 1, D_NONE, TOUT - 1);
    checkOutput("tout_not_yet_halted", 64'(halted), 64'd0);
    checkOutput("tout_not_yet_error", 64'(busError), 64'd0);
    applyStimulus(0, 0, 1, 1, D_NONE, 1);
    checkOutput("tout_halted", 64'(halted), 64'd1);
    checkOutput("tout_bus_error", 64'(busError), 64'd1);
`else
    applyStimulus(0, 0, 1, 1, D_NONE, 999);
    checkOutput("stall_ifu_valid", 64'(ifuReqValid), 64'd1);
    checkOutput("stall_bus_error", 64'(busError), 64'd0);
    checkOutput("stall_mcycle", 64'(mcycle), 64'd231);
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/ysyx_24070014_multicycle_ctrl.md
Name: ysyx_24070014_multicycle_ctrl

Overview:
- Multi-cycle sequencer replacing implicit single-cycle timing in the core top.
- Drives instruction fetch and data memory through valid/ready handshakes, so memories may take any number of cycles.
- Gates PC, instruction-register and regfile writes so each instruction commits exactly once.
- Keeps cycle and retired-instruction counters; handles ecall/ebreak as single-cycle trap pulses plus a halt state.

Parameters:
- CNT_WIDTH, 64, width of mcycle/minstret counters.
- TIMEOUT_CYCLES, 1024, wait-state limit before bus error (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ifu_req_valid  out  1  fetch request, PC is external.
- ifu_req_ready  in  1  fetch memory accepts request.
- ifu_resp_valid  in  1  instruction data valid this cycle.
- inst_latch_en  out  1  load external instruction register.
- dec_is_load  in  1  decoded load.
- dec_is_store  in  1  decoded store.
- dec_reg_write  in  1  decoded regfile write enable.
- dec_ecall  in  1  decoded ecall.
- dec_ebreak  in  1  decoded ebreak.
- lsu_req_valid  out  1  data memory request.
- lsu_req_ready  in  1  data memory accepts.
- lsu_resp_valid  in  1  load data valid / store done.
- rf_write_en  out  1  gated regfile write.
- pc_write_en  out  1  PC update strobe.
- retire  out  1  one-cycle pulse per committed instruction.
- trap_ecall  out  1  one-cycle pulse.
- trap_ebreak  out  1  one-cycle pulse.
- halted  out  1  high in HALT.
- mcycle  out  CNT_WIDTH  cycles since reset.
- minstret  out  CNT_WIDTH  retired instructions.
- bus_error  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- State encoding lives in the package. States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- Reset: state=FETCH_REQ; mcycle=0, minstret=0, bus_error=0. All strobes and handshake outputs are 0 in the cycle after reset.
- FETCH_REQ:
  - ifu_req_valid=1.
  - On ifu_req_ready go to FETCH_WAIT. If ifu_resp_valid is also high that same cycle, go straight to EXEC and assert inst_latch_en.
- FETCH_WAIT:
  - ifu_req_valid=0.
  - On ifu_resp_valid: inst_latch_en=1, go to EXEC.
- EXEC (decode inputs valid here):
  - If dec_ebreak: trap_ebreak=1, retire=1, go to HALT. PC is not written.
  - Else if dec_ecall: trap_ecall=1, then WB.
  - Else if load or store: go to MEM_REQ.
  - Else: WB.
- MEM_REQ: lsu_req_valid=1 held until lsu_req_ready, then MEM_WAIT.
- MEM_WAIT: on lsu_resp_valid go to WB.
- Load write timing: for loads, rf_write_en=dec_reg_write only in WB. The external core registers load data on lsu_resp_valid.
- WB:
  - rf_write_en=dec_reg_write (forced 0 for stores).
  - pc_write_en=1, retire=1, go to FETCH_REQ.
- Minimum latencies with 0-wait memories: 3 cycles per ALU instruction (FETCH_REQ, EXEC, WB); 5 per load/store.
- Handshake rules:
  - A valid stays high and stable until ready. Valid is never withdrawn.
  - Responses arriving in any other state are ignored.
- HALT:
  - All strobes are 0 and valids are low. Only reset exits.
  - mcycle keeps counting; minstret frozen.
- Counters:
  - mcycle increments every cycle except reset.
  - minstret increments on retire.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- Reset mid-transaction: abandons the outstanding request immediately; valids drop the next cycle.
- Simultaneous dec_ecall and dec_ebreak: ebreak wins.

Optional Feature:
- Macro: YSYX_24070014_BUS_TIMEOUT_EN.
- Defined: a wait counter clears on entry to FETCH_REQ, FETCH_WAIT, MEM_REQ and MEM_WAIT, and increments every cycle spent in them. On reaching TIMEOUT_CYCLES it sets bus_error (sticky until reset) and moves to HALT.
- Undefined: no counter is built; bus_error tied 0; waits are unbounded.

Decomposition:
- Shared package / DEFINITION file:
  - state enum localparams, 3-bit.
  - CNT_WIDTH default.
  - INIT_PC stays there.
- One sub-module: ysyx_24070014_perf_counter, a parametrised width counter with enable and synchronous clear, instanced for mcycle and minstret.

Test Plan:
- ALU stream, both memories 0-wait, 4 non-memory instructions -> retire pulses at cycles 3, 6, 9, 12 after reset release; minstret=4, mcycle=12.
- Fetch with ifu_resp_valid delayed 5 cycles -> ifu_req_valid held until ready; inst_latch_en exactly once; single retire; no pc_write_en before WB.
- Load with lsu_req_ready low 3 cycles, response after 2 more -> lsu_req_valid high 4 cycles; rf_write_en single pulse in WB; store variant -> rf_write_en never high.
- ebreak in EXEC -> trap_ebreak and retire same cycle, halted=1 next cycle. After 100 more cycles: minstret unchanged, mcycle +100, no ifu_req_valid.
- Reset asserted during MEM_WAIT -> next cycle lsu_req_valid=0, counters 0, state FETCH_REQ; a stale lsu_resp_valid causes no write.
- With YSYX_24070014_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, ifu_req_ready stuck 0 -> bus_error=1 and halted=1 after 16 wait cycles. Without the macro: still requesting at cycle 1000, bus_error=0.
